// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl
// Description : Three-source vectored interrupt controller for a pipelined
//               core. Synchronises and edge-detects external lines, holds
//               pending/mask/enable state, picks the highest-priority
//               eligible source, redirects the PC to its handler and saves
//               the return PC. ERET pops the highest active service level.
//               Nesting is tracked implicitly in in_service (idle = 000).
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl #(
    parameter int                     IM_ADDR_BIT = 12,
    parameter logic [IM_ADDR_BIT-1:0] VEC0        = 'h010,
    parameter logic [IM_ADDR_BIT-1:0] VEC1        = 'h020,
    parameter logic [IM_ADDR_BIT-1:0] VEC2        = 'h030
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             irq,
    input  logic                   en,
    input  logic                   id_valid,
    input  logic [IM_ADDR_BIT-1:0] id_pc,
    input  logic                   id_eret,
    input  logic [3:0]             cp0_w_en,
    input  logic [3:0]             cp0_w_data,
    output logic                   inting,
    output logic [2:0]             ints,
    output logic                   redirect,
    output logic [IM_ADDR_BIT-1:0] redirect_pc,
    output logic [2:0]             pending,
    output logic [2:0]             in_service
);

    localparam int c_NSRC = 3;

    // Synchroniser (r_sync1/r_sync2) and edge-detect history (r_sync3)
    logic [2:0]             r_sync1;
    logic [2:0]             r_sync2;
    logic [2:0]             r_sync3;

    // Architectural state
    logic [2:0]             r_pending;
    logic [2:0]             r_in_service;
    logic [2:0]             r_mask;
    logic                   r_ie;
    logic [IM_ADDR_BIT-1:0] r_epc [c_NSRC];

    // Decode
    logic [2:0]             w_rise;
    logic [2:0]             w_cand;
    logic [2:0]             w_take_oh;
    logic [1:0]             w_take_idx;
    logic [2:0]             w_ret_oh;
    logic [1:0]             w_ret_idx;
    logic                   w_take;
    logic                   w_eret;
    logic [IM_ADDR_BIT-1:0] w_vec;

    assign w_rise = r_sync2 & ~r_sync3;

    // A source is eligible only if nothing at its own or higher priority is
    // already being serviced, so equal priority never re-enters itself.
    genvar gi;
    generate
        for (gi = 0; gi < c_NSRC; gi++) begin : g_cand
            assign w_cand[gi] = r_pending[gi] & r_mask[gi] & ~(|r_in_service[2:gi]);
        end
    endgenerate

    // Pick the highest-priority candidate (2 > 1 > 0)
    always_comb begin
        w_take_oh  = 3'b000;
        w_take_idx = 2'd0;
        if (w_cand[2]) begin
            w_take_oh  = 3'b100;
            w_take_idx = 2'd2;
        end else if (w_cand[1]) begin
            w_take_oh  = 3'b010;
            w_take_idx = 2'd1;
        end else if (w_cand[0]) begin
            w_take_oh  = 3'b001;
            w_take_idx = 2'd0;
        end
    end

    // ERET returns from the innermost (highest-priority) active level
    always_comb begin
        w_ret_oh  = 3'b000;
        w_ret_idx = 2'd0;
        if (r_in_service[2]) begin
            w_ret_oh  = 3'b100;
            w_ret_idx = 2'd2;
        end else if (r_in_service[1]) begin
            w_ret_oh  = 3'b010;
            w_ret_idx = 2'd1;
        end else if (r_in_service[0]) begin
            w_ret_oh  = 3'b001;
            w_ret_idx = 2'd0;
        end
    end

    assign w_take = r_ie & en & id_valid & (|w_cand);
    // A take in the same cycle squashes the ERET; it re-executes later.
    assign w_eret = id_eret & en & id_valid & ~w_take & (|r_in_service);

    // Handler vector for the selected source
    always_comb begin
        w_vec = VEC0;
        case (w_take_idx)
            2'd1:    w_vec = VEC1;
            2'd2:    w_vec = VEC2;
            default: w_vec = VEC0;
        endcase
    end

    // Zero-latency redirect outputs; everything is 0 when idle
    always_comb begin
        inting      = 1'b0;
        ints        = 3'b000;
        redirect    = 1'b0;
        redirect_pc = '0;
        if (w_take) begin
            inting      = 1'b1;
            ints        = w_take_oh;
            redirect    = 1'b1;
            redirect_pc = w_vec;
        end else if (w_eret) begin
            redirect    = 1'b1;
            redirect_pc = r_epc[w_ret_idx];
        end
    end

    assign pending    = r_pending;
    assign in_service = r_in_service;

    // Two-flop synchroniser plus edge-detect flop on each irq line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_sync3 <= 3'b000;
        end else begin
            r_sync1 <= irq;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // CP0 mask / global-enable writes, independent of pipeline advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= 3'b000;
            r_ie   <= 1'b0;
        end else begin
            for (int i = 0; i < c_NSRC; i++) begin
                if (cp0_w_en[i]) begin
                    r_mask[i] <= cp0_w_data[i];
                end
            end
            if (cp0_w_en[3]) begin
                r_ie <= cp0_w_data[3];
            end
        end
    end

    // Pending latch: a fresh edge wins over the clear from its own take
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 3'b000;
        end else begin
            r_pending <= (r_pending & ~(w_take ? w_take_oh : 3'b000)) | w_rise;
        end
    end

    // Service nesting state and saved return PCs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_service <= 3'b000;
            for (int i = 0; i < c_NSRC; i++) begin
                r_epc[i] <= '0;
            end
        end else begin
            if (w_take) begin
                r_in_service <= r_in_service | w_take_oh;
            end else if (w_eret) begin
                r_in_service <= r_in_service & ~w_ret_oh;
            end
            for (int i = 0; i < c_NSRC; i++) begin
                if (w_take && w_take_oh[i]) begin
                    r_epc[i] <= id_pc;
                end
            end
        end
    end

endmodule
`default_nettype wire
